wide_add_seq: RTL and testbench
===============================

Name: wide_add_seq

Overview:
- Sequenced multi-word adder/subtractor: computes a W = N*WORDS bit add or subtract by reusing one N-bit ripple-carry slice (rca_nbit) over WORDS consecutive cycles.
- Carry is held in a register between cycles.
- Trades latency for area; sits between an operand producer and a result consumer.
- Uses valid/ready handshakes on both sides.

Parameters:
N, 4, bit width of the rca_nbit slice (one word)
WORDS, 4, number of words per operation; must be >= 1; total width W = N*WORDS

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  W  operand A
b  input  W  operand B
cin  input  1  carry-in for add; ignored when sub=1
sub  input  1  1 = compute a - b (two's complement)
busy  output  1  high in RUN or DONE
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
sum  output  W  registered result
cout  output  1  registered carry-out of word WORDS-1 (for sub: 1 = no borrow)
ovf  output  1  signed overflow of the full W-bit operation

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at an edge): state=IDLE, idx=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 after the edge. Reset overrides everything, including mid-operation; the partial result is discarded.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready:
    - capture a into op_a.
    - capture b into op_b, or ~b when sub=1.
    - set carry reg to cin, or to 1 when sub=1.
    - idx=0; go to RUN.
  - RUN: in_ready=0.
    - Each cycle the slice adds op_a[idx*N +: N] + op_b[idx*N +: N] + carry reg.
    - Slice sum is written to sum[idx*N +: N]; carry reg <= slice cout.
    - If idx==WORDS-1: cout <= slice cout, ovf <= computed, go to DONE. Otherwise idx++.
  - DONE: out_valid=1; sum/cout/ovf held stable until the edge where out_ready=1, then go to IDLE (out_valid low next cycle).
- Latency: if the accept handshake is at edge E0, out_valid is visible after edge E_WORDS (WORDS cycles). With WORDS=1 it is visible after E1.
- Throughput: one op per WORDS+2 cycles minimum (accept, WORDS RUN edges, DONE handshake edge). No overlap of DONE with a new accept.
- in_valid while not in IDLE is ignored; the producer must hold it. a/b/cin/sub are sampled only at the accept edge; later changes have no effect.
- ovf = (op_a[W-1] == op_b[W-1]) && (final sum[W-1] != op_a[W-1]), using op_b after inversion.
- Upper sum words are not cleared at accept. Consumers read sum only while out_valid=1; sum keeps its last value in IDLE.
- All arithmetic is modulo 2^W; no saturation.
- idx width = max(1, $clog2(WORDS)). Wrap is never reached because the transition occurs at WORDS-1.

Decomposition:
- Package wide_add_pkg:
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE}.
  - Helper function idx_width(words).
- Sub-module: single instance of the existing rca_nbit #(.N(N)) as the datapath slice. The FSM, operand registers, carry register and result registers live in wide_add_seq.

Test Plan (N=4, WORDS=4, W=16):
1. Carry across words: a=0x00FF, b=0x0001, cin=0, sub=0 -> sum=0x0100, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
2. Full ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0xFFFE, b=0x0000, cin=1 -> sum=0xFFFF, cout=0.
3. Subtract:
   - a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0.
   - a=0x0007, b=0x0005, sub=1, cin=0 -> sum=0x0002, cout=1; cin is ignored.
4. Signed overflow: a=0x7FFF, b=0x0001 add -> sum=0x8000, ovf=1. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
5. Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a -> sum/cout/ovf stable, in_ready=0, no new accept. Then out_ready=1 -> IDLE, and the next op is accepted with the new operands and computes correctly.
6. Reset mid-op: drive rst_n=0 for one edge while idx=2 -> after the edge state=IDLE, out_valid=0, busy=0, sum=0, in_ready=1. A following op a=0x1234, b=0x1111 -> sum=0x2345.

Source files
------------

// File: rtl/wide_add_pkg.sv
`default_nettype none
// wide_add_pkg: shared state encoding and sizing helper for the sequenced wide adder.
// Rev 1.0
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word index width; a single-word build still needs one bit of index.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca_nbit.sv
`default_nettype none
// rca_nbit: N-bit ripple-carry adder slice.
// Rev 1.0
module rca_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[N];

endmodule
`default_nettype wire

// File: rtl/wide_add_seq.sv
`default_nettype none
// wide_add_seq: W = N*WORDS bit add/subtract computed one N-bit word per cycle.
// Rev 1.0
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = N * WORDS;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [W-1:0]    op_a_q;
  logic [W-1:0]    op_b_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            ovf_q;
  logic            in_ready_q;
  logic            busy_q;
  logic            out_valid_q;

  int              word_lsb_d;
  logic [N-1:0]    slice_sum_d;
  logic            slice_cout_d;
  logic            ovf_d;

  assign word_lsb_d = 32'(idx_q) * N;

  rca_nbit #(.N(N)) u_slice (
    .a_i    (op_a_q[word_lsb_d +: N]),
    .b_i    (op_b_q[word_lsb_d +: N]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum_d),
    .cout_o (slice_cout_d)
  );

  // Only meaningful on the last word, where the slice MSB is the result MSB.
  assign ovf_d = (op_a_q[W-1] == op_b_q[W-1]) && (slice_sum_d[N-1] != op_a_q[W-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_a_q     <= a;
            op_b_q     <= sub ? ~b : b;
            carry_q    <= sub | cin;
            idx_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_q[word_lsb_d +: N] <= slice_sum_d;
          carry_q                <= slice_cout_d;
          if (idx_q == LAST_IDX) begin
            cout_q      <= slice_cout_d;
            ovf_q       <= ovf_d;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// tb_wide_add_seq: directed self-checking bench for wide_add_seq (N=4/WORDS=4 and N=16/WORDS=1).
// Rev 1.0
module tb_wide_add_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_valid1;
  logic        in_ready, in_ready1;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        busy, busy1;
  logic        out_valid, out_valid1;
  logic        out_ready, out_ready1;
  logic [15:0] sum, sum1;
  logic        cout, cout1;
  logic        ovf, ovf1;

  int n_pass  = 0;
  int n_total = 0;

  wide_add_seq #(.N(4), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  wide_add_seq #(.N(16), .WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub), .busy(busy1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Waits (bounded) for out_valid and returns the number of edges waited.
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tcin, input logic tsub,
                       input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    a = ~ta; b = ~tb; cin = ~tcin; sub = ~tsub;
    chk({tag, "_busy_run"}, busy, 1);
    chk({tag, "_in_ready_run"}, in_ready, 0);
    wait_done(lat);
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0; out_ready1 = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);

    // Single-word build: result after one RUN edge.
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    chk("w1_busy", busy1, 1);
    chk("w1_ov_before", out_valid1, 0);
    step();
    chk("w1_ov_after_e1", out_valid1, 1);
    chk("w1_sum", sum1, 16'h8000);
    chk("w1_ovf", ovf1, 1);
    chk("w1_cout", cout1, 0);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("w1_idle", in_ready1, 1);

    do_op("carry",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("cin",     16'hFFFE, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    do_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    do_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure: DONE holds while the producer keeps in_valid high with moving operands.
    a = 16'h1000; b = 16'h0234; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done(lat);
    chk("bp_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 16'h4000 + 16'(i);
      step();
      chk("bp_sum_hold", sum, 16'h1234);
      chk("bp_ov_hold", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_cout", cout, 0);
    chk("bp_ovf", ovf, 0);
    a = 16'h0100; b = 16'h0200; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_ov", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_sum_kept", sum, 16'h1234);
    step();
    in_valid = 1'b0;
    chk("bp_next_busy", busy, 1);
    wait_done(lat);
    chk("bp_next_latency", lat, 4);
    chk("bp_next_sum", sum, 16'h0300);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-operation after two RUN edges (word index at 2).
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_ready", in_ready, 1);
    do_op("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
